// File: rtl/if_fetch_queue.sv
// Prefetching instruction-fetch stage: sequential SRAM reads buffered in a DEPTH-entry FIFO toward ID.
// Build option IF_ADEL_CHECK_EN: misaligned fetch addresses become exception entries instead of SRAM reads.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_e,
  input  logic [31:0]      br_addr,
  output logic             inst_sram_en,
  output logic [3:0]       inst_sram_wen,
  output logic [31:0]      inst_sram_addr,
  output logic [31:0]      inst_sram_wdata,
  input  logic [31:0]      inst_sram_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_excp,
  output logic [CNT_W-1:0] queue_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      fetch_pc;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic             inflight_excp;
  logic             stalled;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      q_pc   [DEPTH];
  logic [31:0]      q_inst [DEPTH];
  logic             q_excp [DEPTH];

  logic [CNT_W:0]   reserved;
  logic             room;
  logic             take;
  logic             bad_addr;
  logic             push;
  logic             pop;

  // Issue stage: the in-flight request already owns a slot, so a full queue never overflows.
  assign reserved = {1'b0, count} + (CNT_W+1)'(inflight);
  assign room     = reserved < (CNT_W+1)'(DEPTH);
  assign take     = !rst && (br_e || (room && !stalled));

  assign inst_sram_addr  = br_e ? br_addr : fetch_pc;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;

`ifdef IF_ADEL_CHECK_EN
  assign bad_addr = inst_sram_addr[1:0] != 2'b00;
`else
  assign bad_addr = 1'b0;
`endif

  assign inst_sram_en = take && !bad_addr;

  assign push = inflight && !br_e && !rst;
  assign out_valid = !rst && (count != '0) && !br_e;
  assign pop  = out_valid && out_ready;

  assign queue_count = count;
  assign out_pc   = (count != '0) ? q_pc[head]   : 32'd0;
  assign out_inst = (count != '0) ? q_inst[head] : 32'd0;
  assign out_excp = (count != '0) ? q_excp[head] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      stalled  <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (take) begin
        fetch_pc <= inst_sram_addr + 32'd4;
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end
      // A faulting address freezes fetch until the next redirect.
      stalled <= br_e ? bad_addr : (stalled || (take && bad_addr));
      if (br_e) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push && !pop)
          count <= count + 1'b1;
        else if (pop && !push)
          count <= count - 1'b1;
      end
    end
  end

  // Return stage: SRAM data lands one cycle after its request.
  always_ff @(posedge clk) begin
    if (take) begin
      inflight_pc   <= inst_sram_addr;
      inflight_excp <= bad_addr;
    end
    if (push) begin
      q_pc[tail]   <= inflight_pc;
      q_inst[tail] <= inflight_excp ? 32'd0 : inst_sram_rdata;
      q_excp[tail] <= inflight_excp;
    end
  end

endmodule
